st_channel_adapter_skid: RTL and testbench
==========================================

# st_channel_adapter_skid

Parametrised Avalon-ST channel adapter: it sits between a packet source and a channelised byte/word sink on the RLDRAMII debug-master path. It latches the channel at start-of-packet and width-converts it. It validates the channel against a legal range and either flags or drops bad packets. All outputs come from a two-entry skid buffer, giving full throughput with registered handshakes.

## Interface
Parameters:
- DATA_W, 8, payload width in bits (≥1)
- IN_CHAN_W, 1, input channel width (≥1)
- OUT_CHAN_W, 8, output channel width (≥1)
- MAX_CHAN, 255, highest legal channel number; values above it are out of range
- BAD_CHAN_MODE, 0, 0 = forward bad packet with out_error on every beat; 1 = drop whole packet

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- in_ready  out  1  sink can accept a beat
- in_valid  in  1  source beat valid
- in_data  in  DATA_W  payload
- in_channel  in  IN_CHAN_W  channel; sampled only on SOP beats
- in_startofpacket  in  1  first beat
- in_endofpacket  in  1  last beat
- out_ready  in  1  downstream accepts
- out_valid  out  1  output beat valid
- out_data  out  DATA_W  payload
- out_channel  out  OUT_CHAN_W  latched channel, zero-extended or truncated
- out_startofpacket  out  1  first beat
- out_endofpacket  out  1  last beat
- out_error  out  1  beat belongs to an out-of-range packet (mode 0 only)
- drop_count  out  16  packets dropped; saturates at 16'hFFFF
- protocol_err  out  1  sticky framing error; cleared only by reset

## Operation
- A beat is accepted when in_valid && in_ready; an output beat is transferred when out_valid && out_ready.
- Channel check on an SOP beat: bad when in_channel > MAX_CHAN, or when in_channel ≥ 2^OUT_CHAN_W and would be truncated.
- The checked value is latched and applied to all beats of the packet. in_channel on non-SOP beats is ignored.
- State machine, updated on accepted beats only:
  - IDLE: on SOP with a good channel -> PASS. On SOP with a bad channel: mode 0 -> PASS with err flag set; mode 1 -> DROP.
  - IDLE, SOP+EOP on the same beat: the single-beat packet is forwarded or dropped, and the state stays IDLE.
  - IDLE, non-SOP beat: discard the beat, set protocol_err, stay IDLE.
  - PASS: forward each beat; EOP -> IDLE. A SOP inside PASS starts a new packet: set protocol_err, re-latch the channel, and re-evaluate PASS/DROP. No synthetic EOP is inserted.
  - DROP: discard beats; EOP -> IDLE and drop_count+1. A SOP inside DROP is handled as in PASS.
- Dropped and discarded beats never enter the skid buffer. in_ready gating is unchanged while dropping.
- out_error equals the latched err flag in mode 0 and is always 0 in mode 1.

## Timing
- Reset values: in_ready 0, out_valid 0, out_data/out_channel/out_startofpacket/out_endofpacket/out_error 0, drop_count 0, protocol_err 0, state IDLE, skid buffer empty.
- in_ready rises on the first clk edge after reset deasserts.
- Latency: a beat accepted at edge N is presented on out_* after edge N; it is therefore valid in cycle N+1.
- Throughput: one beat per clock while out_ready is high.
- in_ready is registered and equals !(skid entry occupied). After out_ready drops with out_valid high, at most one further beat is accepted; in_ready falls on the next edge.
- While out_valid && !out_ready, all out_* signals hold stable.
- Reset asserted mid-packet empties the buffer immediately (asynchronously), forces IDLE, and clears drop_count and protocol_err. A partial packet is never completed.
- drop_count increments on the edge that accepts the EOP of a dropped packet. At 16'hFFFF it holds.

## Structure
- Package st_adapter_pkg holds the state enum (IDLE, PASS, DROP) and the BAD_CHAN_MODE constants MODE_FLAG=0 and MODE_DROP=1.
- Sub-module st_skid_buffer: two-entry registered buffer, parametrised on payload width. Its payload is DATA_W + OUT_CHAN_W + 3 bits (data, channel, SOP, EOP, error).
- The top level contains the channel check, the FSM, and the counters.

## Test plan
- Reset release, then a 4-beat packet on channel 1 with data 0x10..0x13, out_ready=1 -> out carries the same beats one cycle later with out_channel=8'h01, SOP on beat 0, EOP on beat 3, no bubbles.
- MAX_CHAN=3, mode 1, packet on channel 5 followed by a packet on channel 2 -> only the channel-2 packet appears and drop_count=1. Mode 0 with the same stimulus -> both packets appear; the channel-5 packet has out_error=1 on every beat.
- Continuous input with out_ready toggling 1,0,0,1 -> no beat lost or duplicated, in_ready low for exactly the stall window plus one cycle, out_* stable during the stall.
- Framing errors:
  - non-SOP beat in IDLE -> discarded, protocol_err=1.
  - SOP mid-packet on channel 2 -> the new packet is forwarded with out_channel=2, and the old packet has no EOP.
- Reset pulse mid-packet with 1 beat buffered -> out_valid=0 immediately; the next packet after release is forwarded normally.
- Preload drop_count to 16'hFFFF with 65535 dropped single-beat SOP+EOP packets, then drop one more -> drop_count stays 16'hFFFF.

Source files
------------

// File: rtl/st_adapter_pkg.sv
// Shared types and constants for the Avalon-ST channel adapter.
//   state_e   : packet framing state (idle, forwarding, dropping)
//   MODE_FLAG : bad-channel packets are forwarded with out_error set
//   MODE_DROP : bad-channel packets are discarded and counted
package st_adapter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPass,
        StDrop
    } state_e;

    localparam int unsigned MODE_FLAG = 0;
    localparam int unsigned MODE_DROP = 1;

endpackage

// File: rtl/st_skid_buffer.sv
// Two-entry registered skid buffer (valid/ready).
//   clk_i, rst_i              : clock, asynchronous active-high reset
//   in_valid_i/in_ready_o     : upstream handshake; in_ready_o is a register
//   in_data_i                 : upstream payload
//   out_valid_o/out_ready_i   : downstream handshake; outputs come from registers
//   out_data_o                : downstream payload
// The output register is the primary entry; the skid register catches the one
// beat that can arrive in the cycle after downstream stalls.
module st_skid_buffer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o
);

    logic             out_valid_q, out_valid_d;
    logic [Width-1:0] out_data_q, out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [Width-1:0] skid_data_q, skid_data_d;
    logic             ready_q, ready_d;
    logic             push, pop;

    assign push = in_valid_i && ready_q;
    assign pop  = out_valid_q && out_ready_i;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (skid_valid_q) begin
            // in_ready is low while the skid entry is full, so no push here.
            if (pop) begin
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (push) begin
            if (!out_valid_q || pop) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data_i;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data_i;
            end
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
        // Separate register so in_ready stays low during reset and rises one edge later.
        ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            ready_q      <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            ready_q      <= ready_d;
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

endmodule

// File: rtl/st_channel_adapter_skid.sv
// Avalon-ST channel adapter with range check and registered skid output.
//   clk, reset                  : clock, asynchronous active-high reset
//   in_*                        : Avalon-ST sink (valid/ready, data, channel, SOP, EOP)
//   out_*                       : Avalon-ST source; out_channel is the latched SOP channel,
//                                 zero-extended or truncated to OUT_CHAN_W; out_error marks
//                                 beats of out-of-range packets (flag mode only)
//   drop_count                  : saturating count of dropped packets
//   protocol_err                : sticky framing error (orphan beat or SOP mid-packet)
module st_channel_adapter_skid
    import st_adapter_pkg::*;
#(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned IN_CHAN_W     = 1,
    parameter int unsigned OUT_CHAN_W    = 8,
    parameter int unsigned MAX_CHAN      = 255,
    parameter int unsigned BAD_CHAN_MODE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  in_ready,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [IN_CHAN_W-1:0]  in_channel,
    input  logic                  in_startofpacket,
    input  logic                  in_endofpacket,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic [OUT_CHAN_W-1:0] out_channel,
    output logic                  out_startofpacket,
    output logic                  out_endofpacket,
    output logic                  out_error,
    output logic [15:0]           drop_count,
    output logic                  protocol_err
);

    localparam int unsigned PayW     = DATA_W + OUT_CHAN_W + 3;
    localparam int unsigned CmpW     = (IN_CHAN_W > 32) ? IN_CHAN_W : 32;
    localparam bit          DropMode = (BAD_CHAN_MODE == MODE_DROP);

    // Channel check, evaluated only on SOP beats.
    logic [CmpW-1:0]       chan_ext;
    logic                  chan_range_bad;
    logic                  chan_trunc_bad;
    logic                  chan_bad;
    logic [OUT_CHAN_W-1:0] chan_conv;

    assign chan_ext       = CmpW'(in_channel);
    assign chan_range_bad = chan_ext > CmpW'(MAX_CHAN);
    assign chan_conv      = OUT_CHAN_W'(in_channel);

    if (IN_CHAN_W > OUT_CHAN_W) begin : g_trunc
        assign chan_trunc_bad = |in_channel[IN_CHAN_W-1:OUT_CHAN_W];
    end else begin : g_no_trunc
        assign chan_trunc_bad = 1'b0;
    end

    assign chan_bad = chan_range_bad || chan_trunc_bad;

    state_e                state_q, state_d;
    logic [OUT_CHAN_W-1:0] chan_q, chan_d;
    logic                  err_q, err_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  proto_q, proto_d;

    logic                  accept;
    logic                  fwd;
    logic                  drop_inc;
    logic                  proto_set;
    logic                  beat_err;
    logic [OUT_CHAN_W-1:0] beat_chan;

    assign accept = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        err_d     = err_q;
        fwd       = 1'b0;
        drop_inc  = 1'b0;
        proto_set = 1'b0;
        beat_err  = err_q;
        beat_chan = chan_q;
        if (accept) begin
            if (in_startofpacket) begin
                // SOP always opens a new packet; inside a packet it is also a framing error.
                proto_set = (state_q != StIdle);
                chan_d    = chan_conv;
                err_d     = chan_bad;
                beat_chan = chan_conv;
                beat_err  = chan_bad;
                if (chan_bad && DropMode) begin
                    if (in_endofpacket) begin
                        drop_inc = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        state_d  = StDrop;
                    end
                end else begin
                    fwd     = 1'b1;
                    state_d = in_endofpacket ? StIdle : StPass;
                end
            end else begin
                unique case (state_q)
                    StIdle: proto_set = 1'b1;
                    StPass: begin
                        fwd = 1'b1;
                        if (in_endofpacket) state_d = StIdle;
                    end
                    StDrop: begin
                        if (in_endofpacket) begin
                            drop_inc = 1'b1;
                            state_d  = StIdle;
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
        cnt_d   = (drop_inc && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
        proto_d = proto_q || proto_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            chan_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            proto_q <= 1'b0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            proto_q <= proto_d;
        end
    end

    logic [PayW-1:0] skid_in;
    logic [PayW-1:0] skid_out;
    logic            flag_err;

    assign flag_err = !DropMode && beat_err;
    assign skid_in  = {in_data, beat_chan, in_startofpacket, in_endofpacket, flag_err};

    st_skid_buffer #(
        .Width (PayW)
    ) u_skid (
        .clk_i       (clk),
        .rst_i       (reset),
        .in_valid_i  (fwd),
        .in_ready_o  (in_ready),
        .in_data_i   (skid_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (skid_out)
    );

    assign {out_data, out_channel, out_startofpacket, out_endofpacket, out_error} = skid_out;
    assign drop_count   = cnt_q;
    assign protocol_err = proto_q;

endmodule

// File: tb/tb_st_channel_adapter_skid.sv
module tb_st_channel_adapter_skid;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic [7:0] in_channel = 8'h00;
    logic       in_sop = 1'b0;
    logic       in_eop = 1'b0;
    logic       out_ready = 1'b1;

    logic        o0_in_ready, o0_valid, o0_sop, o0_eop, o0_err, o0_perr;
    logic [7:0]  o0_data, o0_chan;
    logic [15:0] o0_drop;
    logic        o1_in_ready, o1_valid, o1_sop, o1_eop, o1_err, o1_perr;
    logic [7:0]  o1_data, o1_chan;
    logic [15:0] o1_drop;

    wire [19:0] o0_vec = {o0_valid, o0_data, o0_chan, o0_sop, o0_eop, o0_err};
    wire [19:0] o1_vec = {o1_valid, o1_data, o1_chan, o1_sop, o1_eop, o1_err};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Flag mode instance
    st_channel_adapter_skid #(
        .DATA_W(8), .IN_CHAN_W(8), .OUT_CHAN_W(8), .MAX_CHAN(3), .BAD_CHAN_MODE(0)
    ) dut0 (
        .clk(clk), .reset(reset), .in_ready(o0_in_ready), .in_valid(in_valid),
        .in_data(in_data), .in_channel(in_channel), .in_startofpacket(in_sop),
        .in_endofpacket(in_eop), .out_ready(out_ready), .out_valid(o0_valid),
        .out_data(o0_data), .out_channel(o0_chan), .out_startofpacket(o0_sop),
        .out_endofpacket(o0_eop), .out_error(o0_err), .drop_count(o0_drop),
        .protocol_err(o0_perr)
    );

    // Drop mode instance
    st_channel_adapter_skid #(
        .DATA_W(8), .IN_CHAN_W(8), .OUT_CHAN_W(8), .MAX_CHAN(3), .BAD_CHAN_MODE(1)
    ) dut1 (
        .clk(clk), .reset(reset), .in_ready(o1_in_ready), .in_valid(in_valid),
        .in_data(in_data), .in_channel(in_channel), .in_startofpacket(in_sop),
        .in_endofpacket(in_eop), .out_ready(out_ready), .out_valid(o1_valid),
        .out_data(o1_data), .out_channel(o1_chan), .out_startofpacket(o1_sop),
        .out_endofpacket(o1_eop), .out_error(o1_err), .drop_count(o1_drop),
        .protocol_err(o1_perr)
    );

    task automatic drive(input logic v, input logic [7:0] d, input logic [7:0] c,
                         input logic s, input logic e);
        in_valid   = v;
        in_data    = d;
        in_channel = c;
        in_sop     = s;
        in_eop     = e;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        out_ready = 1'b1;
        step();
        step();
        checks++;
        if ({o0_in_ready, o0_vec, o0_drop, o0_perr} !== 38'h0) begin
            errors++;
            $display("FAIL reset_state0: got %h expected 0", {o0_in_ready, o0_vec, o0_drop, o0_perr});
        end
        checks++;
        if ({o1_in_ready, o1_vec, o1_drop, o1_perr} !== 38'h0) begin
            errors++;
            $display("FAIL reset_state1: got %h expected 0", {o1_in_ready, o1_vec, o1_drop, o1_perr});
        end
        reset = 1'b0;
        #1;
        checks++;
        if (o0_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b expected 0", o0_in_ready);
        end
        step();
        checks++;
        if ({o0_in_ready, o1_in_ready} !== 2'b11) begin
            errors++;
            $display("FAIL ready_after_edge: got %b expected 11", {o0_in_ready, o1_in_ready});
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) begin
            logic [7:0] d;
            logic [19:0] exp;
            d = 8'h10 + 8'(i);
            drive(1'b1, d, 8'h01, i == 0, i == 3);
            step();
            exp = {1'b1, d, 8'h01, i == 0, i == 3, 1'b0};
            checks++;
            if (o0_vec !== exp) begin
                errors++;
                $display("FAIL basic0 beat %0d: got %h expected %h", i, o0_vec, exp);
            end
            checks++;
            if (o1_vec !== exp) begin
                errors++;
                $display("FAIL basic1 beat %0d: got %h expected %h", i, o1_vec, exp);
            end
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        step();
        checks++;
        if ({o0_valid, o1_valid} !== 2'b00) begin
            errors++;
            $display("FAIL basic_drain: got %b expected 00", {o0_valid, o1_valid});
        end
    endtask

    task automatic test_bad_channel();
        logic [7:0] dat [5] = '{8'h20, 8'h21, 8'h22, 8'h30, 8'h31};
        for (int i = 0; i < 5; i++) begin
            logic        s, e, bad;
            logic [7:0]  c, lc;
            logic [19:0] exp;
            s   = (i == 0) || (i == 3);
            e   = (i == 2) || (i == 4);
            bad = (i < 3);
            lc  = bad ? 8'h05 : 8'h02;
            c   = s ? lc : 8'hAA;  // non-SOP channel must be ignored
            drive(1'b1, dat[i], c, s, e);
            step();
            exp = {1'b1, dat[i], lc, s, e, bad};
            checks++;
            if (o0_vec !== exp) begin
                errors++;
                $display("FAIL flag_mode beat %0d: got %h expected %h", i, o0_vec, exp);
            end
            if (bad) begin
                checks++;
                if (o1_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL drop_mode_valid beat %0d: got %b expected 0", i, o1_valid);
                end
            end else begin
                exp = {1'b1, dat[i], lc, s, e, 1'b0};
                checks++;
                if (o1_vec !== exp) begin
                    errors++;
                    $display("FAIL drop_mode beat %0d: got %h expected %h", i, o1_vec, exp);
                end
            end
            checks++;
            if (o1_drop !== ((i >= 2) ? 16'd1 : 16'd0)) begin
                errors++;
                $display("FAIL drop_count beat %0d: got %0d expected %0d", i, o1_drop, (i >= 2));
            end
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        step();
        checks++;
        if ({o0_drop, o0_perr, o1_perr} !== 18'h0) begin
            errors++;
            $display("FAIL bad_chan_side: got %h expected 0", {o0_drop, o0_perr, o1_perr});
        end
    endtask

    task automatic test_stall();
        int         sent = 0;
        logic [7:0] rx[$];
        for (int k = 0; k < 12; k++) begin
            logic exp_rdy;
            out_ready = !((k == 1) || (k == 2));
            if (sent < 6) drive(1'b1, 8'h40 + 8'(sent), 8'h02, sent == 0, sent == 5);
            else drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
            exp_rdy = !((k == 2) || (k == 3));
            checks++;
            if ({o0_in_ready, o1_in_ready} !== {exp_rdy, exp_rdy}) begin
                errors++;
                $display("FAIL stall_ready cycle %0d: got %b expected %b", k,
                         {o0_in_ready, o1_in_ready}, {exp_rdy, exp_rdy});
            end
            if (k >= 1 && k <= 3) begin
                checks++;
                if ({o0_vec, o1_vec} !== {2{1'b1, 8'h40, 8'h02, 1'b1, 1'b0, 1'b0}}) begin
                    errors++;
                    $display("FAIL stall_hold cycle %0d: got %h expected stable beat 40", k,
                             {o0_vec, o1_vec});
                end
            end
            if (o0_valid && out_ready) rx.push_back(o0_data);
            if (in_valid && o0_in_ready) sent++;
            step();
        end
        out_ready = 1'b1;
        checks++;
        if (rx.size() != 6) begin
            errors++;
            $display("FAIL stall_count: got %0d expected 6", rx.size());
        end else begin
            for (int j = 0; j < 6; j++) begin
                checks++;
                if (rx[j] !== 8'h40 + 8'(j)) begin
                    errors++;
                    $display("FAIL stall_order %0d: got %h expected %h", j, rx[j], 8'h40 + 8'(j));
                end
            end
        end
    endtask

    task automatic test_framing();
        logic [7:0] dat [4] = '{8'h60, 8'h61, 8'h70, 8'h71};
        logic [7:0] lch [4] = '{8'h01, 8'h01, 8'h02, 8'h02};
        drive(1'b1, 8'h55, 8'h01, 1'b0, 1'b0);
        step();
        checks++;
        if ({o0_valid, o1_valid, o0_perr, o1_perr} !== 4'b0011) begin
            errors++;
            $display("FAIL orphan_beat: got %b expected 0011", {o0_valid, o1_valid, o0_perr, o1_perr});
        end
        for (int i = 0; i < 4; i++) begin
            logic        s, e;
            logic [19:0] exp;
            s = (i == 0) || (i == 2);
            e = (i == 3);
            drive(1'b1, dat[i], s ? lch[i] : 8'hAA, s, e);
            step();
            exp = {1'b1, dat[i], lch[i], s, e, 1'b0};
            checks++;
            if ({o0_vec, o1_vec} !== {exp, exp}) begin
                errors++;
                $display("FAIL sop_mid_packet beat %0d: got %h expected %h", i, {o0_vec, o1_vec},
                         {exp, exp});
            end
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, 8'h80, 8'h01, 1'b1, 1'b0);
        step();
        checks++;
        if (o0_vec !== {1'b1, 8'h80, 8'h01, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midreset_buffered: got %h expected %h", o0_vec,
                     {1'b1, 8'h80, 8'h01, 1'b1, 1'b0, 1'b0});
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({o0_valid, o1_valid, o0_in_ready, o0_perr, o1_perr, o1_drop} !== 21'h0) begin
            errors++;
            $display("FAIL midreset_async: got %h expected 0",
                     {o0_valid, o1_valid, o0_in_ready, o0_perr, o1_perr, o1_drop});
        end
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        step();
        checks++;
        if (o0_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_ready: got %b expected 1", o0_in_ready);
        end
        drive(1'b1, 8'h90, 8'h03, 1'b1, 1'b0);
        step();
        checks++;
        if ({o0_vec, o1_vec} !== {2{1'b1, 8'h90, 8'h03, 1'b1, 1'b0, 1'b0}}) begin
            errors++;
            $display("FAIL midreset_next0: got %h", {o0_vec, o1_vec});
        end
        drive(1'b1, 8'h91, 8'h00, 1'b0, 1'b1);
        step();
        checks++;
        if ({o0_vec, o1_vec} !== {2{1'b1, 8'h91, 8'h03, 1'b0, 1'b1, 1'b0}}) begin
            errors++;
            $display("FAIL midreset_next1: got %h", {o0_vec, o1_vec});
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_saturate();
        out_ready = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            drive(1'b1, 8'(i), 8'h05, 1'b1, 1'b1);
            step();
            if (i == 2) begin
                checks++;
                if (o1_drop !== 16'd3) begin
                    errors++;
                    $display("FAIL drop_count_early: got %0d expected 3", o1_drop);
                end
            end
        end
        checks++;
        if (o1_drop !== 16'hFFFF) begin
            errors++;
            $display("FAIL drop_count_full: got %h expected ffff", o1_drop);
        end
        drive(1'b1, 8'hEE, 8'h05, 1'b1, 1'b1);
        step();
        checks++;
        if (o1_drop !== 16'hFFFF) begin
            errors++;
            $display("FAIL drop_count_saturate: got %h expected ffff", o1_drop);
        end
        checks++;
        if ({o0_vec, o0_drop} !== {1'b1, 8'hEE, 8'h05, 1'b1, 1'b1, 1'b1, 16'h0}) begin
            errors++;
            $display("FAIL flag_single_beat: got %h expected %h", {o0_vec, o0_drop},
                     {1'b1, 8'hEE, 8'h05, 1'b1, 1'b1, 1'b1, 16'h0});
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_channel();
        test_stall();
        test_framing();
        test_reset_mid();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
